sys_cfg_reg_bank: RTL and testbench
===================================

# sys_cfg_reg_bank

Configuration register bank in the sys_clk domain. It sits directly downstream of the dcb_clk→sys_clk word-transfer stage and consumes its single-cycle valid/data words. Each word is decoded as a command: shadow-register write, commit, or shadow clear. A commit copies the shadow set atomically into the active set and raises a request/acknowledge handshake toward the consuming logic.

## Interface
Parameters:
- DATA_WIDTH, 32, command word width; must be ≥ 9.
- ADDR_WIDTH, 4, register address width; 2^ADDR_WIDTH ≥ NUM_REGS.
- NUM_REGS, 12, number of configuration registers; legal range 1..2^ADDR_WIDTH.
- REG_WIDTH, DATA_WIDTH-8, width of each register.

Ports:
- sys_clk  in  1  sole clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- sys_in_val  in  1  command word valid; one word per cycle max, back-to-back allowed.
- sys_in_data  in  DATA_WIDTH  command word.
- cfg_regs  out  NUM_REGS*REG_WIDTH  active register set; register i occupies bits [i*REG_WIDTH +: REG_WIDTH].
- cfg_req  out  1  active set updated; level signal, held until acknowledged.
- cfg_ack  in  1  consumer acknowledge.
- wr_cnt  out  16  accepted shadow writes, saturating.
- err_cnt  out  8  rejected commands, saturating.
- err_pulse  out  1  one-cycle pulse per rejected command.

## Operation
- Word fields: opcode = sys_in_data[DATA_WIDTH-1 -: 4]; addr = sys_in_data[DATA_WIDTH-5 -: 4], low ADDR_WIDTH bits used; upper addr bits must be zero; payload = sys_in_data[REG_WIDTH-1:0].
- Opcode 0x1 WRITE: shadow[addr] ← payload; wr_cnt increments. Rejected if addr ≥ NUM_REGS or upper addr bits are nonzero.
- Opcode 0x2 COMMIT: legal only in state IDLE. Active set ← entire shadow set in the same edge; state → REQ. Addr and payload are ignored.
- Opcode 0x3 CLEAR: all shadow registers ← 0; the active set is untouched. Legal in any state.
- Any other opcode is rejected.
- A rejected command changes no state except the error signals: err_cnt increments and err_pulse is asserted.
- FSM, two states:
  - IDLE: cfg_req = 0. A legal COMMIT moves to REQ.
  - REQ: cfg_req = 1. Sampling cfg_ack = 1 moves to IDLE. A COMMIT arriving in REQ is rejected, including in the same cycle as cfg_ack, so the active set stays stable for the whole time cfg_req is high.
- cfg_ack is ignored in IDLE.
- WRITE and CLEAR are accepted in both states; they only touch the shadow set.
- Both counters saturate: wr_cnt at 0xFFFF, err_cnt at 0xFF. A rejection at saturation still produces err_pulse.
- Reset, including assertion mid-REQ: all shadow and active registers, wr_cnt, err_cnt, err_pulse and cfg_req are cleared asynchronously. The FSM returns to IDLE.

## Timing
- All outputs are registered. Reset value of every output is 0.
- A word sampled at edge N takes effect at edge N. Its results (cfg_regs, cfg_req, counters, err_pulse) are visible from cycle N+1, so latency is 1 cycle.
- WRITE at edge N followed by COMMIT at edge N+1: the commit captures the new value. No bypass is needed, because shadow is already updated.
- WRITE in the same cycle as a REQ→IDLE ack: the write is applied and the ack is applied.
- cfg_ack sampled high at edge M while cfg_req = 1: cfg_req = 0 from cycle M+1. A COMMIT at edge M+1 is legal.
- err_pulse is high for exactly one cycle per rejected word. Back-to-back rejections keep it high on consecutive cycles, and err_cnt increments once per word.
- No combinational path from any input to any output.

## Test plan
- Reset, then WRITE 0x1_3_ABCDEF, then COMMIT: shadow[3] = 0xABCDEF. cfg_regs[3] = 0xABCDEF and cfg_req = 1 one cycle after the commit edge. wr_cnt = 1 and err_cnt = 0.
- With cfg_req = 1, WRITE reg 5 = 0x000011, then COMMIT: the commit is rejected, err_pulse for 1 cycle, err_cnt = 1, and cfg_regs[5] stays 0. After cfg_ack, a second COMMIT succeeds and cfg_regs[5] = 0x000011.
- Opcode 0x7, then WRITE to addr 12 (NUM_REGS = 12) on back-to-back cycles: err_pulse is high 2 cycles, err_cnt = 2, and wr_cnt and shadow are unchanged.
- WRITE reg 0 = 0x123456 at edge N, COMMIT at N+1, cfg_ack held high continuously: cfg_regs[0] = 0x123456, and cfg_req is high for exactly one cycle.
- CLEAR followed by COMMIT after registers 0..11 have been loaded with nonzero values: cfg_regs is all zero. CLEAR issued while cfg_req = 1 leaves cfg_regs unchanged.
- 65540 WRITEs: wr_cnt holds 0xFFFF. Assert sys_rst mid-REQ, asynchronously between edges: cfg_req, cfg_regs and the counters read 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/sys_cfg_reg_bank.sv
// sys_cfg_reg_bank: command-driven config register bank with shadow/active sets and commit handshake
// Ports:
//   sys_clk, sys_rst      clock, async active-high reset
//   sys_in_val/_data      one command word per cycle: {opcode[3:0], addr[3:0], payload}
//   cfg_regs              active register set, register i at [i*REG_WIDTH +: REG_WIDTH]
//   cfg_req / cfg_ack     level request raised by a commit, dropped when ack is sampled
//   wr_cnt, err_cnt       saturating counts of accepted writes / rejected commands
//   err_pulse             one cycle high per rejected command
module sys_cfg_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 12,
  parameter int REG_WIDTH  = DATA_WIDTH - 8
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          sys_in_val,
  input  logic [DATA_WIDTH-1:0]         sys_in_data,
  output logic [NUM_REGS*REG_WIDTH-1:0] cfg_regs,
  output logic                          cfg_req,
  input  logic                          cfg_ack,
  output logic [15:0]                   wr_cnt,
  output logic [7:0]                    err_cnt,
  output logic                          err_pulse
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;
  logic [0:0]                    r_state;
  logic [REG_WIDTH-1:0]          r_shadow [NUM_REGS];
  logic [NUM_REGS*REG_WIDTH-1:0] r_cfg;
  logic [15:0]                   r_wr_cnt;
  logic [7:0]                    r_err_cnt;
  logic                          r_err_pulse;
  logic [3:0]                    w_op;
  logic [3:0]                    w_field;
  logic [ADDR_WIDTH-1:0]         w_addr;
  logic [REG_WIDTH-1:0]          w_payload;
  logic                          w_addr_ok;
  logic                          w_wr_ok;
  logic                          w_cm_ok;
  logic                          w_clr;
  logic                          w_rej;
  assign w_op      = sys_in_data[DATA_WIDTH-1 -: 4];
  assign w_field   = sys_in_data[DATA_WIDTH-5 -: 4];
  assign w_addr    = w_field[ADDR_WIDTH-1:0];
  assign w_payload = sys_in_data[REG_WIDTH-1:0];
  // field bits above ADDR_WIDTH must be zero and the address must name an existing register
  assign w_addr_ok = ((w_field >> ADDR_WIDTH) == 4'd0) && (32'(w_addr) < NUM_REGS);
  assign w_wr_ok   = sys_in_val && w_op == 4'h1 && w_addr_ok;
  // a commit in REQ is refused even alongside an ack so the active set never moves while cfg_req is high
  assign w_cm_ok   = sys_in_val && w_op == 4'h2 && r_state == S_IDLE;
  assign w_clr     = sys_in_val && w_op == 4'h3;
  assign w_rej     = sys_in_val && !(w_wr_ok || w_cm_ok || w_clr);
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
      r_cfg       <= '0;
      r_state     <= S_IDLE;
      r_wr_cnt    <= '0;
      r_err_cnt   <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_clr) r_shadow[i] <= '0;
        else if (w_wr_ok && 32'(w_addr) == i) r_shadow[i] <= w_payload;
        if (w_cm_ok) r_cfg[i*REG_WIDTH +: REG_WIDTH] <= r_shadow[i];
      end
      r_state     <= w_cm_ok ? S_REQ : (r_state == S_REQ && cfg_ack) ? S_IDLE : r_state;
      r_err_pulse <= w_rej;
      if (w_wr_ok && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_rej && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
  assign cfg_regs  = r_cfg;
  assign cfg_req   = r_state == S_REQ;
  assign wr_cnt    = r_wr_cnt;
  assign err_cnt   = r_err_cnt;
  assign err_pulse = r_err_pulse;
endmodule

// File: tb/tb_sys_cfg_reg_bank.sv
// tb_sys_cfg_reg_bank: directed self-checking bench for sys_cfg_reg_bank
module tb_sys_cfg_reg_bank;
  logic        sys_clk;
  logic        sys_rst;
  logic        sys_in_val;
  logic [31:0] sys_in_data;
  logic [287:0] cfg_regs;
  logic        cfg_req;
  logic        cfg_ack;
  logic [15:0] wr_cnt;
  logic [7:0]  err_cnt;
  logic        err_pulse;
  int passed = 0;
  int total = 0;
  sys_cfg_reg_bank dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_in_val(sys_in_val), .sys_in_data(sys_in_data),
    .cfg_regs(cfg_regs), .cfg_req(cfg_req), .cfg_ack(cfg_ack),
    .wr_cnt(wr_cnt), .err_cnt(err_cnt), .err_pulse(err_pulse)
  );
  initial begin
    sys_clk = 0;
    forever #5 sys_clk = ~sys_clk;
  end
  function automatic logic [23:0] reg_of(input int i);
    return cfg_regs[i*24 +: 24];
  endfunction
  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic step(input logic v, input logic [31:0] d);
    sys_in_val = v;
    sys_in_data = d;
    @(posedge sys_clk);
    #1;
    sys_in_val = 0;
    sys_in_data = 0;
  endtask
  initial begin
    sys_rst = 1; sys_in_val = 0; sys_in_data = 0; cfg_ack = 0;
    @(posedge sys_clk); @(posedge sys_clk); #1;
    sys_rst = 0;
    chk("rst_regs", cfg_regs, 0);
    chk("rst_req", cfg_req, 0);
    chk("rst_wr", wr_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_pulse", err_pulse, 0);
    step(1, 32'h13ABCDEF);
    chk("wr1_cnt", wr_cnt, 1);
    chk("wr1_req", cfg_req, 0);
    step(1, 32'h20000000);
    chk("cm1_reg3", reg_of(3), 24'hABCDEF);
    chk("cm1_req", cfg_req, 1);
    chk("cm1_wr", wr_cnt, 1);
    chk("cm1_err", err_cnt, 0);
    step(1, 32'h15000011);
    chk("wr5_cnt", wr_cnt, 2);
    step(1, 32'h20000000);
    chk("cmrej_pulse", err_pulse, 1);
    chk("cmrej_err", err_cnt, 1);
    chk("cmrej_reg5", reg_of(5), 0);
    chk("cmrej_req", cfg_req, 1);
    step(0, 0);
    chk("cmrej_pulse_off", err_pulse, 0);
    cfg_ack = 1;
    step(0, 0);
    cfg_ack = 0;
    chk("ack_req", cfg_req, 0);
    step(1, 32'h20000000);
    chk("cm2_req", cfg_req, 1);
    chk("cm2_reg5", reg_of(5), 24'h000011);
    chk("cm2_reg3", reg_of(3), 24'hABCDEF);
    cfg_ack = 1;
    step(0, 0);
    cfg_ack = 0;
    step(1, 32'h70000000);
    chk("badop_pulse", err_pulse, 1);
    chk("badop_err", err_cnt, 2);
    step(1, 32'h1C000099);
    chk("badaddr_pulse", err_pulse, 1);
    chk("badaddr_err", err_cnt, 3);
    chk("badaddr_wr", wr_cnt, 2);
    step(0, 0);
    chk("bad_pulse_off", err_pulse, 0);
    step(1, 32'h10123456);
    cfg_ack = 1;
    step(1, 32'h20000000);
    chk("ackhi_req_on", cfg_req, 1);
    chk("ackhi_reg0", reg_of(0), 24'h123456);
    step(1, 32'h11000777);
    chk("ackhi_req_off", cfg_req, 0);
    chk("ackwr_cnt", wr_cnt, 4);
    step(0, 0);
    chk("ackhi_req_stay", cfg_req, 0);
    cfg_ack = 0;
    step(1, 32'h20000000);
    chk("cm3_reg1", reg_of(1), 24'h000777);
    cfg_ack = 1;
    step(1, 32'h20000000);
    cfg_ack = 0;
    chk("cmack_pulse", err_pulse, 1);
    chk("cmack_err", err_cnt, 4);
    chk("cmack_req", cfg_req, 0);
    step(1, 32'h20000000);
    chk("cm_after_ack_req", cfg_req, 1);
    chk("cm_after_ack_pulse", err_pulse, 0);
    cfg_ack = 1;
    step(0, 0);
    cfg_ack = 0;
    for (int i = 0; i < 12; i++) step(1, {4'h1, 4'(i), 24'h000100 + 24'(i)});
    chk("fill_wr", wr_cnt, 16);
    step(1, 32'h20000000);
    chk("fill_reg0", reg_of(0), 24'h000100);
    chk("fill_reg11", reg_of(11), 24'h00010B);
    step(1, 32'h30000000);
    chk("clrreq_reg11", reg_of(11), 24'h00010B);
    chk("clrreq_pulse", err_pulse, 0);
    cfg_ack = 1;
    step(0, 0);
    cfg_ack = 0;
    step(1, 32'h20000000);
    chk("clr_all_zero", cfg_regs, 0);
    chk("clr_req", cfg_req, 1);
    cfg_ack = 1;
    step(0, 0);
    cfg_ack = 0;
    for (int i = 0; i < 65540; i++) step(1, 32'h10000001);
    chk("wr_sat", wr_cnt, 16'hFFFF);
    for (int i = 0; i < 260; i++) step(1, 32'hF0000000);
    chk("err_sat", err_cnt, 8'hFF);
    chk("err_sat_pulse", err_pulse, 1);
    step(1, 32'h20000000);
    chk("pre_rst_req", cfg_req, 1);
    chk("pre_rst_reg0", reg_of(0), 24'h000001);
    #2;
    sys_rst = 1;
    #1;
    chk("arst_req", cfg_req, 0);
    chk("arst_regs", cfg_regs, 0);
    chk("arst_wr", wr_cnt, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_pulse", err_pulse, 0);
    @(posedge sys_clk); #1;
    sys_rst = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
